// File: rtl/fir_dp_ram_ctrl.sv
// Dual-port word RAM for FIR sample/coefficient buffers, two Avalon-MM slaves, byte-merged same-address writes.
// Latency: reads return READ_LATENCY (1 or 2) cycles after acceptance; writes land at the accepting edge.
// Backpressure: waitrequest is high in IDLE_RST and during the zero-fill; otherwise every transfer is accepted.
module fir_dp_ram_ctrl #(
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 10,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                s2_waitrequest,
  input  logic                clear_req,
  output logic                busy
);

  localparam int BYTES = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE_RST, CLEAR, READY} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic              ready;

  logic [DATA_W-1:0] mem [DEPTH];

  // Per-port views so both slaves share one pipeline description
  logic [ADDR_W-1:0] p_addr [2];
  logic [BYTES-1:0]  p_be   [2];
  logic [DATA_W-1:0] p_wdat [2];
  logic [DATA_W-1:0] p_rdat [2];
  logic [1:0]        p_wr;
  logic [1:0]        p_rd;
  logic [1:0]        p_rvld;

  assign p_addr[0] = s1_address;
  assign p_addr[1] = s2_address;
  assign p_be[0]   = s1_byteenable;
  assign p_be[1]   = s2_byteenable;
  assign p_wdat[0] = s1_writedata;
  assign p_wdat[1] = s2_writedata;

  // waitrequest depends on registered state only, never on the request inputs
  assign ready          = (state == READY);
  assign busy           = !ready;
  assign s1_waitrequest = !ready;
  assign s2_waitrequest = !ready;

  // A write on the same port wins over a read; the read is dropped
  assign p_wr[0] = ready && s1_chipselect && s1_write;
  assign p_wr[1] = ready && s2_chipselect && s2_write;
  assign p_rd[0] = ready && s1_chipselect && s1_read && !s1_write;
  assign p_rd[1] = ready && s2_chipselect && s2_read && !s2_write;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE_RST;
    else          state <= state_nxt;
  end

  // Next-state: leave CLEAR on the cycle the last address is written; clear_req only honoured in READY
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE_RST: state_nxt = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      CLEAR:    if (&clr_cnt) state_nxt = READY;
      READY:    if (clear_req) state_nxt = CLEAR;
      default:  state_nxt = IDLE_RST;
    endcase
  end

  // Clear address counter; natural wrap leaves it at 0 when CLEAR exits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            clr_cnt <= '0;
    else if (state == CLEAR) clr_cnt <= clr_cnt + ADDR_W'(1);
  end

  // Array writes: zero-fill in CLEAR, else byte lanes from both ports with s1 owning contested bytes
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[clr_cnt] <= '0;
    for (int b = 0; b < BYTES; b++) begin
      if (p_wr[0] && p_be[0][b])
        mem[p_addr[0]][b*8 +: 8] <= p_wdat[0][b*8 +: 8];
      if (p_wr[1] && p_be[1][b] && !(p_wr[0] && p_be[0][b] && (p_addr[0] == p_addr[1])))
        mem[p_addr[1]][b*8 +: 8] <= p_wdat[1][b*8 +: 8];
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic              vld1;
    logic [DATA_W-1:0] dat1;

    // First read stage samples the array before this edge's writes land (old-data semantics)
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vld1 <= 1'b0;
        dat1 <= '0;
      end else begin
        vld1 <= p_rd[p];
        if (p_rd[p]) dat1 <= mem[p_addr[p]];
      end
    end

    if (READ_LATENCY == 2) begin : g_lat2
      logic              vld2;
      logic [DATA_W-1:0] dat2;

      // Optional output register; data holds between valid pulses
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          vld2 <= 1'b0;
          dat2 <= '0;
        end else begin
          vld2 <= vld1;
          if (vld1) dat2 <= dat1;
        end
      end

      assign p_rvld[p] = vld2;
      assign p_rdat[p] = dat2;
    end else begin : g_lat1
      assign p_rvld[p] = vld1;
      assign p_rdat[p] = dat1;
    end
  end

  assign s1_readdata      = p_rdat[0];
  assign s2_readdata      = p_rdat[1];
  assign s1_readdatavalid = p_rvld[0];
  assign s2_readdatavalid = p_rvld[1];

endmodule
